// File: rtl/ga_req_arbiter.sv
// ---------------------------------------------------------------------------
// ga_pkg / ga_req_arbiter
//
// Purpose:
//   Round-robin arbiter and sequencer that shares one ga_coprocessor between
//   NUM_REQ requesters. One operation is in flight at a time. The grant is
//   accepted in IDLE, the request is driven onto the coprocessor handshake
//   (ISSUE), the arbiter waits for the result (WAIT_RESP), and a one-cycle
//   strobe (RESPOND) returns the result to the requester that was granted.
//   A timeout guard covers ISSUE+WAIT_RESP. Coprocessor results that arrive
//   when none is expected are counted in a saturating counter.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester request valid
//   req_i        per-requester request payload (.valid field ignored)
//   req_ready_o  one-hot accept, combinational from req_valid_i, IDLE only
//   rsp_valid_o  one-hot, one-cycle response strobe
//   rsp_result_o result for the strobed requester (held until next RESPOND)
//   rsp_err_o    timeout flag, qualified by rsp_valid_o
//   ga_req_o     request to the coprocessor
//   ga_resp_i    response from the coprocessor (.ready, .valid, .result)
//   busy_o       FSM is not in IDLE
//   grant_idx_o  index of the current/last granted requester
//   stale_cnt_o  saturating count of unexpected ga_resp_i.valid
// ---------------------------------------------------------------------------

package ga_pkg;

   typedef enum logic [2:0] {
      GA_ADD  = 3'd0,
      GA_SUB  = 3'd1,
      GA_MUL  = 3'd2,
      GA_DIV  = 3'd3,
      GA_SQRT = 3'd4,
      GA_MIN  = 3'd5,
      GA_MAX  = 3'd6,
      GA_CMP  = 3'd7
   } ga_funct_e;

   typedef struct packed {
      logic        valid;
      ga_funct_e   funct;
      logic [31:0] operand_a;
      logic [31:0] operand_b;
   } ga_req_t;

   typedef struct packed {
      logic        ready;
      logic        valid;
      logic [31:0] result;
   } ga_resp_t;

endpackage

module ga_req_arbiter
   import ga_pkg::*;
#(
   parameter  int NUM_REQ        = 4,
   parameter  int TIMEOUT_CYCLES = 64,
   localparam int IDX_W          = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  ga_req_t            req_i [NUM_REQ],
   output logic [NUM_REQ-1:0] req_ready_o,
   output logic [NUM_REQ-1:0] rsp_valid_o,
   output logic [31:0]        rsp_result_o,
   output logic               rsp_err_o,
   output ga_req_t            ga_req_o,
   input  ga_resp_t           ga_resp_i,
   output logic               busy_o,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic [7:0]         stale_cnt_o
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2,
      RESPOND   = 2'd3
   } state_e;

   state_e               state_r;
   state_e               state_next_s;
   logic [IDX_W-1:0]     last_r;
   logic [IDX_W-1:0]     grant_idx_r;
   logic [TMO_W-1:0]     tmo_r;
   ga_req_t              ga_req_r;
   logic [NUM_REQ-1:0]   rsp_valid_r;
   logic [31:0]          rsp_result_r;
   logic                 rsp_err_r;
   logic [7:0]           stale_r;

   logic                 win_found_s;
   logic [IDX_W-1:0]     win_idx_s;
   logic [IDX_W-1:0]     cand_s;
   logic                 take_s;
   logic                 complete_s;
   logic                 timeout_s;
   logic                 stale_s;

   // Round-robin winner: first valid requester after the last one granted.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s = IDX_W'((int'(last_r) + k) % NUM_REQ);
         if (!win_found_s && req_valid_i[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Event decode and next-state logic for the sequencing FSM.
   always_comb begin
      take_s       = (state_r == IDLE) && win_found_s;
      complete_s   = ((state_r == ISSUE) && ga_resp_i.ready && ga_resp_i.valid) ||
                     ((state_r == WAIT_RESP) && ga_resp_i.valid);
      timeout_s    = ((state_r == ISSUE) || (state_r == WAIT_RESP)) &&
                     (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));
      // A result strobe that cannot belong to the in-flight op.
      stale_s      = ga_resp_i.valid &&
                     ((state_r == IDLE) || (state_r == RESPOND) ||
                      ((state_r == ISSUE) && !ga_resp_i.ready));
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (take_s) begin
               state_next_s = ISSUE;
            end else begin
               state_next_s = IDLE;
            end
         end
         ISSUE: begin
            // Completion has priority over the timeout in the same cycle.
            if (complete_s || timeout_s) begin
               state_next_s = RESPOND;
            end else if (ga_resp_i.ready) begin
               state_next_s = WAIT_RESP;
            end else begin
               state_next_s = ISSUE;
            end
         end
         WAIT_RESP: begin
            if (complete_s || timeout_s) begin
               state_next_s = RESPOND;
            end else begin
               state_next_s = WAIT_RESP;
            end
         end
         RESPOND: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register, datapath capture and response registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= IDLE;
         last_r       <= IDX_W'(NUM_REQ - 1);
         grant_idx_r  <= '0;
         tmo_r        <= '0;
         ga_req_r     <= '0;
         rsp_valid_r  <= '0;
         rsp_result_r <= 32'd0;
         rsp_err_r    <= 1'b0;
         stale_r      <= 8'd0;
      end else begin
         state_r <= state_next_s;

         if (take_s) begin
            ga_req_r    <= req_i[win_idx_s];
            grant_idx_r <= win_idx_s;
            last_r      <= win_idx_s;
            tmo_r       <= '0;
         end else if ((state_r == ISSUE) || (state_r == WAIT_RESP)) begin
            tmo_r <= tmo_r + TMO_W'(1);
         end else begin
            tmo_r <= tmo_r;
         end
         // The request is only presented while the FSM sits in ISSUE.
         ga_req_r.valid <= (state_next_s == ISSUE);

         if (state_next_s == RESPOND) begin
            rsp_valid_r  <= NUM_REQ'(1) << grant_idx_r;
            rsp_result_r <= complete_s ? ga_resp_i.result : 32'd0;
            rsp_err_r    <= !complete_s;
         end else begin
            rsp_valid_r  <= '0;
         end

         if (stale_s && (stale_r != 8'hFF)) begin
            stale_r <= stale_r + 8'd1;
         end else begin
            stale_r <= stale_r;
         end
      end
   end

   assign req_ready_o  = take_s ? (NUM_REQ'(1) << win_idx_s) : '0;
   assign rsp_valid_o  = rsp_valid_r;
   assign rsp_result_o = rsp_result_r;
   assign rsp_err_o    = rsp_err_r;
   assign ga_req_o     = ga_req_r;
   assign busy_o       = (state_r != IDLE);
   assign grant_idx_o  = grant_idx_r;
   assign stale_cnt_o  = stale_r;

endmodule

// File: tb/tb_ga_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ga_req_arbiter
//
// Self-checking bench for ga_req_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=64).
// A table of operations (request mask, payload, coprocessor latencies and
// hand-computed winner/result/error/latency) is applied in order; the
// coprocessor is modelled cycle by cycle inside the op task. Stale
// responses and reset during WAIT_RESP are covered by hand sequences.
// ---------------------------------------------------------------------------
module tb_ga_req_arbiter;
   import ga_pkg::*;

   typedef struct {
      logic [3:0]  mask;
      logic        hold;   // keep req_valid asserted after the transfer
      ga_funct_e   funct;
      logic [31:0] a;
      logic [31:0] b;
      int          rdy;    // ISSUE cycle in which ready is given, -1 never
      int          val;    // cycles after ready until valid, -1 never
      int          win;
      logic [31:0] res;
      logic        err;
      int          lat;    // cycles from ISSUE entry to rsp strobe
      logic        gap;    // expect rsp exactly 4 cycles after the previous
   } op_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = 4'b0000;
   ga_req_t     req_pay [4];
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [31:0] rsp_result;
   logic        rsp_err;
   ga_req_t     ga_req;
   ga_resp_t    ga_resp = '0;
   logic        busy;
   logic [1:0]  grant_idx;
   logic [7:0]  stale_cnt;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;
   int last_rsp_at = 0;
   logic [31:0] prev_res = 32'd0;
   op_t tbl [24];

   ga_req_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(64)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_valid_i  (req_valid),
      .req_i        (req_pay),
      .req_ready_o  (req_ready),
      .rsp_valid_o  (rsp_valid),
      .rsp_result_o (rsp_result),
      .rsp_err_o    (rsp_err),
      .ga_req_o     (ga_req),
      .ga_resp_i    (ga_resp),
      .busy_o       (busy),
      .grant_idx_o  (grant_idx),
      .stale_cnt_o  (stale_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic op_t mk(input logic [3:0] mask, input logic hold, input ga_funct_e f,
                              input logic [31:0] a, input logic [31:0] b, input int rdy,
                              input int val, input int win, input logic [31:0] res,
                              input logic err, input int lat, input logic gap);
      op_t o;
      o.mask = mask; o.hold = hold; o.funct = f; o.a = a; o.b = b;
      o.rdy = rdy; o.val = val; o.win = win; o.res = res; o.err = err;
      o.lat = lat; o.gap = gap;
      return o;
   endfunction

   // Runs one operation starting from IDLE (called at negedge+1).
   task automatic do_op(input op_t op);
      int cyc;
      int rsp_cyc;
      logic [3:0] exp_oh;
      exp_oh = 4'b0001 << op.win;
      for (int i = 0; i < 4; i++) begin
         if (i == op.win) begin
            req_pay[i].valid = 1'b0; req_pay[i].funct = op.funct;
            req_pay[i].operand_a = op.a; req_pay[i].operand_b = op.b;
         end else begin
            req_pay[i].valid = 1'b1; req_pay[i].funct = GA_SQRT;
            req_pay[i].operand_a = 32'hDEAD_0000 | 32'(i);
            req_pay[i].operand_b = 32'hFFFF_FFFF;
         end
      end
      req_valid = op.mask;
      #1;
      chk("idle_ready", req_ready, exp_oh);
      chk("idle_busy", busy, 1'b0);
      chk("idle_rsp_valid", rsp_valid, 4'b0000);
      chk("idle_ga_valid", ga_req.valid, 1'b0);
      chk("idle_result_hold", rsp_result, prev_res);
      @(negedge clk);
      if (!op.hold) req_valid = 4'b0000;
      #1;
      chk("issue_ga_valid", ga_req.valid, 1'b1);
      chk("issue_funct", ga_req.funct, op.funct);
      chk("issue_opa", ga_req.operand_a, op.a);
      chk("issue_opb", ga_req.operand_b, op.b);
      chk("issue_grant", grant_idx, op.win);
      chk("issue_busy", busy, 1'b1);
      chk("issue_ready", req_ready, 4'b0000);
      cyc = 0;
      rsp_cyc = -1;
      while (rsp_cyc < 0 && cyc < 200) begin
         ga_resp.ready  = (op.rdy >= 0) && (cyc == op.rdy);
         ga_resp.valid  = (op.rdy >= 0) && (op.val >= 0) && (cyc == op.rdy + op.val);
         ga_resp.result = ga_resp.valid ? op.res : 32'h0BAD_F00D;
         @(negedge clk);
         cyc = cyc + 1;
         #1;
         if (rsp_valid != 4'b0000) rsp_cyc = cyc;
         else chk("wait_ga_valid", ga_req.valid, (op.rdy < 0) || (cyc <= op.rdy));
      end
      ga_resp = '0;
      chk("rsp_latency", rsp_cyc, op.lat);
      chk("rsp_onehot", rsp_valid, exp_oh);
      chk("rsp_result", rsp_result, op.err ? 32'd0 : op.res);
      chk("rsp_err", rsp_err, op.err);
      chk("rsp_ga_valid", ga_req.valid, 1'b0);
      chk("rsp_no_grant", req_ready, 4'b0000);
      if (op.gap) chk("rsp_gap", cyc_cnt - last_rsp_at, 4);
      last_rsp_at = cyc_cnt;
      prev_res = op.err ? 32'd0 : op.res;
      @(negedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) req_pay[i] = '0;
      // Fairness: all four requesters hold valid, zero-wait coprocessor.
      for (int k = 0; k < 16; k++)
         tbl[k] = mk(4'b1111, 1'b1, GA_ADD, 32'(k % 4), 32'h0000_0010, 0, 1, k % 4,
                     32'hA000_0000 | 32'(k), 1'b0, 2, k > 0);
      tbl[16] = mk(4'b0001, 1'b0, GA_ADD, 32'h3F80_0000, 32'h4000_0000, 1, 2, 0,
                   32'h4040_0000, 1'b0, 4, 1'b0);
      tbl[17] = mk(4'b1010, 1'b0, GA_MUL, 32'h4000_0000, 32'h4040_0000, 0, 0, 1,
                   32'h40C0_0000, 1'b0, 1, 1'b0);
      tbl[18] = mk(4'b0101, 1'b0, GA_DIV, 32'h40C0_0000, 32'h4000_0000, 2, 1, 2,
                   32'h4040_0000, 1'b0, 4, 1'b0);
      tbl[19] = mk(4'b0011, 1'b0, GA_ADD, 32'h4000_0000, 32'h4000_0000, 0, 2, 0,
                   32'h4080_0000, 1'b0, 3, 1'b0);
      tbl[20] = mk(4'b1001, 1'b0, GA_MUL, 32'h3FC0_0000, 32'h4000_0000, 3, 0, 3,
                   32'h4040_0000, 1'b0, 4, 1'b0);
      // Timeout from WAIT_RESP (ready but never valid).
      tbl[21] = mk(4'b0100, 1'b0, GA_SUB, 32'h4000_0000, 32'h3F80_0000, 2, -1, 2,
                   32'h0, 1'b1, 64, 1'b0);
      // Completion in the timeout cycle wins.
      tbl[22] = mk(4'b0010, 1'b0, GA_MAX, 32'h4000_0000, 32'h40A0_0000, 0, 63, 1,
                   32'h40A0_0000, 1'b0, 64, 1'b0);
      // Coprocessor never responds at all.
      tbl[23] = mk(4'b0001, 1'b0, GA_MIN, 32'h1111_1111, 32'h2222_2222, -1, -1, 0,
                   32'h0, 1'b1, 64, 1'b0);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_busy", busy, 1'b0);
      chk("reset_ga_req", ga_req, '0);
      chk("reset_ready", req_ready, 4'b0000);
      chk("reset_rsp_valid", rsp_valid, 4'b0000);
      chk("reset_rsp_result", rsp_result, 32'd0);
      chk("reset_rsp_err", rsp_err, 1'b0);
      chk("reset_grant", grant_idx, 2'd0);
      chk("reset_stale", stale_cnt, 8'd0);

      for (int r = 0; r < 24; r++) do_op(tbl[r]);

      // Late coprocessor result in IDLE is stale and produces no response.
      chk("stale_before", stale_cnt, 8'd0);
      ga_resp.valid = 1'b1;
      ga_resp.result = 32'h1234_5678;
      @(negedge clk); #1;
      ga_resp = '0;
      chk("stale_idle_cnt", stale_cnt, 8'd1);
      chk("stale_idle_rsp", rsp_valid, 4'b0000);
      chk("stale_idle_busy", busy, 1'b0);
      @(negedge clk); #1;
      chk("stale_idle_rsp2", rsp_valid, 4'b0000);
      chk("stale_idle_result", rsp_result, prev_res);

      // Stale valid in ISSUE without ready, then reset during WAIT_RESP.
      req_pay[2].funct = GA_ADD;
      req_valid = 4'b0100;
      #1;
      chk("seqb_ready", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      chk("seqb_grant", grant_idx, 2'd2);
      chk("seqb_busy", busy, 1'b1);
      ga_resp.valid = 1'b1;
      ga_resp.ready = 1'b0;
      @(negedge clk); #1;
      chk("seqb_stale_issue", stale_cnt, 8'd2);
      chk("seqb_still_issue", ga_req.valid, 1'b1);
      ga_resp.valid = 1'b0;
      ga_resp.ready = 1'b1;
      @(negedge clk); #1;
      chk("seqb_wait_ga_valid", ga_req.valid, 1'b0);
      chk("seqb_wait_busy", busy, 1'b1);
      ga_resp = '0;
      rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_ga_req", ga_req, '0);
      chk("rst_mid_rsp", rsp_valid, 4'b0000);
      chk("rst_mid_stale", stale_cnt, 8'd0);
      chk("rst_mid_grant", grant_idx, 2'd0);
      prev_res = 32'd0;
      do_op(mk(4'b1111, 1'b0, GA_SUB, 32'h4040_0000, 32'h3F80_0000, 0, 1, 0,
               32'h4000_0000, 1'b0, 2, 1'b0));
      chk("final_rsp_valid", rsp_valid, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
